// File: rtl/ext_pipe_pkg.sv
// Shared control encodings for the immediate-extension path.
// Branch-offset modes take the codes after the original three.
package ext_pipe_pkg;

  localparam int unsigned ExtOp_WIDTH = 3;

  localparam logic [ExtOp_WIDTH-1:0] ExtOp_SIGNED     = 3'b000;
  localparam logic [ExtOp_WIDTH-1:0] ExtOp_UNSIGN     = 3'b001;
  localparam logic [ExtOp_WIDTH-1:0] ExtOp_HIGH16     = 3'b010;
  localparam logic [ExtOp_WIDTH-1:0] ExtOp_SIGNED_SL2 = 3'b011;
  localparam logic [ExtOp_WIDTH-1:0] ExtOp_UNSIGN_SL2 = 3'b100;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate widener implementing the extension mode table.
// Unused mode codes produce zero.
module ext_core
  import ext_pipe_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic [IMM_W-1:0]       imm,
  input  logic [ExtOp_WIDTH-1:0] op,
  output logic [DATA_W-1:0]      data
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;

  assign sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  assign zext = {{(DATA_W-IMM_W){1'b0}}, imm};

  always_comb begin
    data = '0;
    case (op)
      ExtOp_SIGNED:     data = sext;
      ExtOp_UNSIGN:     data = zext;
      ExtOp_HIGH16:     data = {imm, {(DATA_W-IMM_W){1'b0}}};
      ExtOp_SIGNED_SL2: data = sext << 2;
      ExtOp_UNSIGN_SL2: data = zext << 2;
      default:          data = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extension: one-cycle latency, output register plus a
// single skid entry so in_ready is a pure flop output.
module ext_pipe
  import ext_pipe_pkg::*;
#(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMM_W-1:0]       in_imm,
  input  logic [ExtOp_WIDTH-1:0] in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [TAG_W-1:0]       out_tag
);

  logic [DATA_W-1:0] ext_data;

  logic              or_valid_q, or_valid_d;
  logic [DATA_W-1:0] or_data_q, or_data_d;
  logic [TAG_W-1:0]  or_tag_q, or_tag_d;
  logic              sk_valid_q, sk_valid_d;
  logic [DATA_W-1:0] sk_data_q, sk_data_d;
  logic [TAG_W-1:0]  sk_tag_q, sk_tag_d;

  logic accept;
  logic drain;

  ext_core #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W)
  ) u_ext_core (
    .imm (in_imm),
    .op  (in_op),
    .data(ext_data)
  );

  // in_ready depends only on the skid flop, never on out_ready.
  assign in_ready  = !sk_valid_q;
  assign accept    = in_valid && in_ready;
  assign drain     = or_valid_q && out_ready;
  assign out_valid = or_valid_q;
  assign out_data  = or_data_q;
  assign out_tag   = or_tag_q;

  always_comb begin
    or_valid_d = or_valid_q;
    or_data_d  = or_data_q;
    or_tag_d   = or_tag_q;
    sk_valid_d = sk_valid_q;
    sk_data_d  = sk_data_q;
    sk_tag_d   = sk_tag_q;

    if (flush) begin
      // Datapath registers keep stale contents; only the valid bits matter.
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || drain) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        or_tag_d   = sk_tag_q;
        sk_valid_d = accept;
        if (accept) begin
          sk_data_d = ext_data;
          sk_tag_d  = in_tag;
        end
      end else begin
        or_valid_d = accept;
        if (accept) begin
          or_data_d = ext_data;
          or_tag_d  = in_tag;
        end
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_data_d  = ext_data;
      sk_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      sk_valid_q <= 1'b0;
      sk_data_q  <= '0;
      sk_tag_q   <= '0;
    end else begin
      or_valid_q <= or_valid_d;
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      sk_valid_q <= sk_valid_d;
      sk_data_q  <= sk_data_d;
      sk_tag_q   <= sk_tag_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Scoreboard bench for ext_pipe: directed mode/back-pressure/flush/reset
// sequences followed by a long randomised handshake run.
module tb_ext_pipe;
  import ext_pipe_pkg::*;

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } sb_entry_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [IMM_W-1:0]       in_imm;
  logic [ExtOp_WIDTH-1:0] in_op;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic [TAG_W-1:0]       out_tag;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  sb_entry_t   sb_q[$];
  logic [31:0] cur_exp;

  ext_pipe #(
    .IMM_W (IMM_W),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_op    (in_op),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [2:0] op);
    logic signed [31:0] s;
    s = 32'(signed'(imm));
    case (op)
      3'd0:    return s;
      3'd1:    return {16'h0000, imm};
      3'd2:    return {imm, 16'h0000};
      3'd3:    return s * 4;
      3'd4:    return {14'h0, imm, 2'b00};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: inputs are applied now (just after a rising edge), the model
  // and checks run on the falling edge, then we return 1 time unit past the
  // next rising edge.
  task automatic step(input logic v, input logic [15:0] imm, input logic [2:0] op,
                      input logic [4:0] tag, input logic [31:0] exp, input logic ordy,
                      input logic fl, input logic r);
    in_valid  = v;
    in_imm    = imm;
    in_op     = op;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    check_eq("out_valid", 64'(out_valid), 64'(sb_q.size() != 0));
    check_eq("in_ready", 64'(in_ready), 64'(sb_q.size() < 2));
    if (out_valid && sb_q.size() != 0) begin
      check_eq("out_data", 64'(out_data), 64'(sb_q[0].data));
      check_eq("out_tag", 64'(out_tag), 64'(sb_q[0].tag));
    end
    if (out_valid && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    if (r || fl) sb_q.delete();
    else if (v && in_ready) sb_q.push_back('{data: exp, tag: tag});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0, 3'd0, 5'd0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_data", 64'(out_data), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming basic modes.
    step(1, 16'h8001, ExtOp_SIGNED, 5'd1, 32'hFFFF8001, 1, 0, 0);
    step(1, 16'h8001, ExtOp_UNSIGN, 5'd2, 32'h00008001, 1, 0, 0);
    step(1, 16'h1234, ExtOp_HIGH16, 5'd3, 32'h12340000, 1, 0, 0);
    // Branch-offset modes and an unused code.
    step(1, 16'hFFFF, ExtOp_SIGNED_SL2, 5'd4, 32'hFFFFFFFC, 1, 0, 0);
    step(1, 16'h7FFF, ExtOp_SIGNED_SL2, 5'd5, 32'h0001FFFC, 1, 0, 0);
    step(1, 16'hFFFF, ExtOp_UNSIGN_SL2, 5'd6, 32'h0003FFFC, 1, 0, 0);
    step(1, 16'hABCD, 3'b111, 5'd7, 32'h00000000, 1, 0, 0);
    idle(1'b1);
    idle(1'b1);

    // Back-pressure: A into OR, B into skid, then drain.
    step(1, 16'h0010, ExtOp_SIGNED, 5'd10, 32'h00000010, 0, 0, 0);
    step(1, 16'h0020, ExtOp_UNSIGN, 5'd11, 32'h00000020, 0, 0, 0);
    check_eq("bp_in_ready_low", 64'(in_ready), 64'd0);
    step(1, 16'h0030, ExtOp_SIGNED, 5'd12, 32'h00000030, 0, 0, 0);
    idle(1'b0);
    idle(1'b1);
    check_eq("bp_in_ready_back", 64'(in_ready), 64'd1);
    check_eq("bp_second_tag", 64'(out_tag), 64'd11);
    idle(1'b1);
    idle(1'b1);

    // Flush with both stages full and an input on offer.
    step(1, 16'h0040, ExtOp_SIGNED, 5'd13, 32'h00000040, 0, 0, 0);
    step(1, 16'h0050, ExtOp_SIGNED, 5'd14, 32'h00000050, 0, 0, 0);
    step(1, 16'h0060, ExtOp_SIGNED, 5'd15, 32'h00000060, 0, 1, 0);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-stream under back-pressure.
    step(1, 16'h0070, ExtOp_HIGH16, 5'd16, 32'h00700000, 0, 0, 0);
    step(1, 16'h0080, ExtOp_HIGH16, 5'd17, 32'h00800000, 0, 0, 0);
    step(0, 16'h0, 3'd0, 5'd0, 32'h0, 0, 0, 1);
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_out_data", 64'(out_data), 64'd0);
    check_eq("mid_rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
    step(1, 16'h8000, ExtOp_SIGNED_SL2, 5'd18, 32'hFFFE0000, 1, 0, 0);
    check_eq("post_rst_data", 64'(out_data), 64'hFFFE0000);
    idle(1'b1);

    // Randomised handshake run.
    for (int i = 0; i < 10000; i++) begin
      logic        v, ordy, fl;
      logic [15:0] imm;
      logic [2:0]  op;
      logic [4:0]  tag;
      v    = ($urandom_range(0, 99) < 60);
      ordy = ($urandom_range(0, 99) < 65);
      fl   = ($urandom_range(0, 99) < 2);
      imm  = 16'($urandom());
      op   = 3'($urandom_range(0, 7));
      tag  = 5'($urandom());
      cur_exp = ref_ext(imm, op);
      step(v, imm, op, tag, cur_exp, ordy, fl, 1'b0);
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_eq("final_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Pipelined, parametrised immediate-extension unit between decode and execute in the MIPS pipeline.
- Widens an IMM_W-bit immediate to DATA_W bits under a mode select.
- Adds two branch-offset modes: sign-extend and shift left 2, and zero-extend and shift left 2.
- Carries each result through a valid/ready output stage with a one-entry skid buffer, so the decode stage can stall or be flushed without losing or duplicating immediates.

Parameters:
- IMM_W, 16, immediate input width.
- DATA_W, 32, result width; DATA_W >= IMM_W+2 required.
- TAG_W, 5, width of the sideband tag (e.g. destination register) carried alongside each result.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered results this cycle.
- in_valid  in  1  imm/op/tag valid.
- in_ready  out  1  unit can accept this cycle.
- in_imm  in  IMM_W  immediate.
- in_op  in  `ExtOp_WIDTH  extension mode.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  extended immediate.
- out_tag  out  TAG_W  tag of out_data.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0, out_data=0, out_tag=0, skid empty, in_ready=1 from the first cycle after reset.
- Extension modes (`ExtOp_WIDTH=3):
  - 000 SIGNED: sign-extend.
  - 001 UNSIGN: zero-extend.
  - 010 HIGH: {imm, (DATA_W-IMM_W) zeros}.
  - 011 SIGNED_SL2: sign-extend, then shift left 2, keeping the low DATA_W bits.
  - 100 UNSIGN_SL2: zero-extend, then shift left 2.
  - 101–111: result 0 and the tag still passes.
- Extension is computed combinationally at the input. Only the registered result is observable.
- Accept: an input is accepted when in_valid && in_ready. The result appears at out_valid/out_data exactly one cycle later if the output register was empty or drained that cycle.
- Latency: 1 cycle. Throughput: 1 per cycle while out_ready=1.
- Storage: output register (OR) plus one skid entry (SK). in_ready = !SK_full, driven from a flop with no combinational path from out_ready.
- Per-cycle update (drain = out_valid && out_ready):
  - OR empty or drain, SK empty: OR <= input if accepted, else OR empty.
  - OR empty or drain, SK full: OR <= SK. SK <= input if accepted, else SK empty.
  - OR full and no drain: an accepted input goes to SK. SK cannot already be full, because in_ready=0 in that case.
- Ordering: strictly in order; a result is never lost or duplicated.
- Hold while stalled: out_data/out_tag stay stable while out_valid=1 and out_ready=0.
- flush: clears OR and SK; out_valid=0 and in_ready=1 next cycle. An input offered in the flush cycle is dropped. Flush overrides a simultaneous accept and drain. A drain in the flush cycle still counts as delivered to the consumer.
- Reset mid-operation: identical to flush, and all outputs return to their reset values.
- Cleared datapath: out_data and out_tag are not required to be cleared on flush, only out_valid. On rst they clear to 0.

Decomposition:
- Shared package / ctrl_encode_def:
  - `ExtOp_WIDTH=3.
  - Mode codes ExtOp_SIGNED, ExtOp_UNSIGN, ExtOp_HIGH16, ExtOp_SIGNED_SL2, ExtOp_UNSIGN_SL2.
  - Existing codes keep their current values; the new codes take 011 and 100.
- Sub-module ext_core: combinational, parametrised on IMM_W/DATA_W, implements the mode table. ext_pipe instantiates ext_core once and holds the handshake, OR, SK and flush logic.

Test Plan:
1. After reset, streaming with out_ready=1: inputs SIGNED 0x8001, UNSIGN 0x8001, HIGH 0x1234 on consecutive cycles -> one cycle later, consecutive outputs 0xFFFF8001, 0x00008001, 0x12340000, with tags matching.
2. Branch modes: SIGNED_SL2 0xFFFF -> 0xFFFFFFFC; SIGNED_SL2 0x7FFF -> 0x0001FFFC; UNSIGN_SL2 0xFFFF -> 0x0003FFFC; op 111 -> 0x00000000.
3. Back-pressure: out_ready=0 while sending A then B -> A held in OR and B in SK, in_ready=0 from the cycle after B. Raise out_ready -> A, then B next cycle; in_ready returns to 1 one cycle after A drains. No loss, no duplication.
4. Flush with OR and SK full and in_valid=1 -> next cycle out_valid=0, in_ready=1; the offered input never appears at the output.
5. Reset asserted mid-stream with out_ready=0 -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1; a post-reset input appears with latency 1.
6. Random valid/ready/flush for 10k cycles against a FIFO scoreboard model -> output order and values match, out_data stable while stalled.
